// File: rtl/jtpopeye_objline.sv
`default_nettype none
// ============================================================================
// Module   : jtpopeye_objline
// Brief    : Double-buffered object line list. Each line, the block collects
//            the objects that hit the next scanline while the renderer reads
//            the previous line's hits.
// Revision : 1.0 - initial release
// ============================================================================
module jtpopeye_objline #(
    parameter int DEPTH       = 32,
    parameter int OBJH        = 16,
    parameter int IDW         = 8,
    parameter int CLR_ON_READ = 1,
    localparam int AW         = $clog2(DEPTH),
    localparam int HB         = $clog2(OBJH),
    localparam int EW         = 3 + 2 + 1 + IDW + HB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_i,
    input  logic              line_start_i,
    input  logic [7:0]        v_i,
    input  logic              vcarry_i,
    input  logic              obj_valid_i,
    input  logic [7:0]        obj_y_i,
    input  logic [7:0]        obj_x_i,
    input  logic [IDW-1:0]    obj_id_i,
    input  logic [2:0]        obj_pal_i,
    input  logic              obj_hflip_i,
    input  logic              obj_vflip_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [EW-1:0]     rd_data_o,
    output logic              rd_valid_o,
    output logic [AW:0]       hit_count_o,
    output logic              overflow_o
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic          wbank_q,    wbank_d;
    logic [AW:0]   wcount_q,   wcount_d;
    logic [AW:0]   rcount_q,   rcount_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic          overflow_q, overflow_d;
    logic [EW-1:0] rd_data_q,  rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic [7:0]        w_sum;
    logic              w_hit;
    logic [HB-1:0]     w_row;
    logic [EW-1:0]     w_entry;
    logic              w_room;
    logic              w_wr_en;
    logic              w_clr_en;
    logic              w_rd_hit;
    logic [EW-1:0]     w_rd_entry;
    logic [1:0][EW-1:0] w_bank_rdata;
    logic              w_unused_x;

    // The renderer carries X[7:2] itself; only the fine position is stored.
    assign w_unused_x = ^obj_x_i[7:2];

    assign w_sum   = obj_y_i + v_i + {7'd0, vcarry_i};
    assign w_hit   = &w_sum[7:HB];
    assign w_row   = w_sum[HB-1:0] ^ {HB{obj_vflip_i}};
    assign w_entry = {obj_pal_i, obj_x_i[1:0], obj_hflip_i, obj_id_i, w_row};

    assign w_room   = wcount_q < C_DEPTH;
    assign w_wr_en  = cen_i && !rst && obj_valid_i && w_hit && !line_start_i && w_room;
    assign w_clr_en = (CLR_ON_READ != 0) && cen_i && !rst && rd_en_i;
    assign w_rd_hit = {1'b0, rd_addr_i} < rcount_q;

    // The read bank is always the one not being written.
    assign w_rd_entry = wbank_q ? w_bank_rdata[0] : w_bank_rdata[1];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic C_BANK = 1'(b);

        logic [EW-1:0] mem_q [DEPTH];
        logic [EW-1:0] w_rdata;
        logic          w_we;
        logic [AW-1:0] w_addr;
        logic [EW-1:0] w_din;

        assign w_rdata         = mem_q[rd_addr_i];
        assign w_bank_rdata[b] = w_rdata;

        // Write-port mux: hit capture when writing, palette clear when reading.
        always_comb begin
            w_we   = 1'b0;
            w_addr = wcount_q[AW-1:0];
            w_din  = w_entry;
            if (w_wr_en && (wbank_q == C_BANK)) begin
                w_we = 1'b1;
            end else if (w_clr_en && (wbank_q != C_BANK)) begin
                w_we   = 1'b1;
                w_addr = rd_addr_i;
                w_din  = {3'b000, w_rdata[EW-4:0]};
            end
        end

        always_ff @(posedge clk) begin
            if (w_we) begin
                mem_q[w_addr] <= w_din;
            end
        end
    end

    always_comb begin
        wbank_d    = wbank_q;
        wcount_d   = wcount_q;
        rcount_d   = rcount_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (cen_i) begin
            if (line_start_i) begin
                wbank_d    = ~wbank_q;
                rcount_d   = wcount_q;
                overflow_d = ovf_pend_q;
                wcount_d   = '0;
                ovf_pend_d = 1'b0;
            end else if (obj_valid_i && w_hit) begin
                if (w_room) begin
                    wcount_d = wcount_q + 1'b1;
                end else begin
                    ovf_pend_d = 1'b1;
                end
            end
            if (rd_en_i) begin
                rd_valid_d = w_rd_hit;
                rd_data_d  = w_rd_hit ? w_rd_entry : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q    <= 1'b0;
            wcount_q   <= '0;
            rcount_q   <= '0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wbank_q    <= wbank_d;
            wcount_q   <= wcount_d;
            rcount_q   <= rcount_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign hit_count_o = wcount_q;
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_jtpopeye_objline.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtpopeye_objline
// Brief    : Directed bench for jtpopeye_objline, clear-on-read on and off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtpopeye_objline;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int EW    = 18;

    logic          clk = 1'b0;
    logic          rst, cen, line_start, vcarry, obj_valid, obj_hflip, obj_vflip, rd_en;
    logic [7:0]    v, obj_y, obj_x, obj_id;
    logic [2:0]    obj_pal;
    logic [AW-1:0] rd_addr;
    logic [EW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, ovf_a, ovf_b;
    logic [AW:0]   hc_a, hc_b;

    always #5 clk = ~clk;

    jtpopeye_objline #(.DEPTH(DEPTH), .OBJH(16), .IDW(8), .CLR_ON_READ(1)) u_dut_a (
        .clk(clk), .rst(rst), .cen_i(cen), .line_start_i(line_start), .v_i(v),
        .vcarry_i(vcarry), .obj_valid_i(obj_valid), .obj_y_i(obj_y), .obj_x_i(obj_x),
        .obj_id_i(obj_id), .obj_pal_i(obj_pal), .obj_hflip_i(obj_hflip),
        .obj_vflip_i(obj_vflip), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .hit_count_o(hc_a), .overflow_o(ovf_a)
    );

    jtpopeye_objline #(.DEPTH(DEPTH), .OBJH(16), .IDW(8), .CLR_ON_READ(0)) u_dut_b (
        .clk(clk), .rst(rst), .cen_i(cen), .line_start_i(line_start), .v_i(v),
        .vcarry_i(vcarry), .obj_valid_i(obj_valid), .obj_y_i(obj_y), .obj_x_i(obj_x),
        .obj_id_i(obj_id), .obj_pal_i(obj_pal), .obj_hflip_i(obj_hflip),
        .obj_vflip_i(obj_vflip), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .hit_count_o(hc_b), .overflow_o(ovf_b)
    );

    typedef struct {
        string         tag;
        logic [EW-1:0] da;
        logic [EW-1:0] db;
        logic          v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [EW-1:0] mk(input logic [2:0] p, input logic [1:0] x,
                                          input logic h, input logic [7:0] id,
                                          input logic [3:0] r);
        return {p, x, h, id, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int hc, input logic ovf);
        chk({tag, "_hc_a"},  32'(hc_a),  32'(hc));
        chk({tag, "_ovf_a"}, 32'(ovf_a), 32'(ovf));
        chk({tag, "_hc_b"},  32'(hc_b),  32'(hc));
        chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(ovf));
    endtask

    task automatic set_obj(input logic [7:0] y, input logic [2:0] p, input logic [7:0] id,
                           input logic [7:0] x, input logic h, input logic vf);
        obj_y = y; obj_pal = p; obj_id = id; obj_x = x;
        obj_hflip = h; obj_vflip = vf; obj_valid = 1'b1;
    endtask

    task automatic obj(input logic [7:0] y, input logic [2:0] p, input logic [7:0] id,
                       input logic [7:0] x, input logic h, input logic vf);
        set_obj(y, p, id, x, h, vf);
        step();
        obj_valid = 1'b0;
    endtask

    task automatic swap();
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic push(input string tag, input logic [EW-1:0] da,
                        input logic [EW-1:0] db, input logic vld);
        exp_t e;
        e.tag = tag; e.da = da; e.db = db; e.v = vld;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({e.tag, "_da"}, 32'(rd_data_a),  32'(e.da));
        chk({e.tag, "_va"}, 32'(rd_valid_a), 32'(e.v));
        chk({e.tag, "_db"}, 32'(rd_data_b),  32'(e.db));
        chk({e.tag, "_vb"}, 32'(rd_valid_b), 32'(e.v));
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [EW-1:0] da,
                      input logic [EW-1:0] db, input logic vld);
        push(tag, da, db, vld);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        pop_chk();
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; line_start = 1'b0; v = 8'h20; vcarry = 1'b0;
        obj_valid = 1'b0; obj_y = '0; obj_x = '0; obj_id = '0; obj_pal = '0;
        obj_hflip = 1'b0; obj_vflip = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_state("reset", 0, 1'b0);
        rd("rst_rd", 5'd0, '0, '0, 1'b0);

        // Basic hit: sum = 0xF5, row 5
        obj(8'hD5, 3'd5, 8'h12, 8'h03, 1'b1, 1'b0);
        chk_state("l1_wr", 1, 1'b0);
        swap();
        chk_state("l1_swap", 0, 1'b0);
        rd("l1_hit", 5'd0, mk(5, 3, 1, 8'h12, 4'h5), mk(5, 3, 1, 8'h12, 4'h5), 1'b1);
        rd("l1_clr", 5'd0, mk(0, 3, 1, 8'h12, 4'h5), mk(5, 3, 1, 8'h12, 4'h5), 1'b1);
        step();
        chk("hold_data", 32'(rd_data_a), 32'(mk(0, 3, 1, 8'h12, 4'h5)));
        chk("hold_valid", 32'(rd_valid_a), 32'd1);
        rd("l1_beyond", 5'd1, '0, '0, 1'b0);

        // vflip, misses, carry-in and the low zone boundary
        obj(8'hD5, 3'd5, 8'h12, 8'h03, 1'b0, 1'b1);
        chk_state("l2_vflip", 1, 1'b0);
        obj(8'hCF, 3'd6, 8'h77, 8'h00, 1'b0, 1'b0);
        chk_state("l2_miss", 1, 1'b0);
        obj(8'hE0, 3'd6, 8'h78, 8'h00, 1'b0, 1'b0);
        chk_state("l2_wrap", 1, 1'b0);
        vcarry = 1'b1;
        obj(8'hD4, 3'd2, 8'h34, 8'h06, 1'b0, 1'b0);
        vcarry = 1'b0;
        chk_state("l2_carry", 2, 1'b0);
        obj(8'hD0, 3'd7, 8'h56, 8'h01, 1'b1, 1'b0);
        chk_state("l2_edge", 3, 1'b0);
        swap();
        rd("l2_0", 5'd0, mk(5, 3, 0, 8'h12, 4'hA), mk(5, 3, 0, 8'h12, 4'hA), 1'b1);
        rd("l2_1", 5'd1, mk(2, 2, 0, 8'h34, 4'h5), mk(2, 2, 0, 8'h34, 4'h5), 1'b1);
        rd("l2_2", 5'd2, mk(7, 1, 1, 8'h56, 4'h0), mk(7, 1, 1, 8'h56, 4'h0), 1'b1);
        rd("l2_3", 5'd3, '0, '0, 1'b0);

        // Overflow: DEPTH+3 hits in one line
        for (int i = 0; i < DEPTH + 3; i++) begin
            obj(8'hD5, 3'(i), 8'(i), 8'h03, 1'b0, 1'b0);
        end
        chk_state("l3_full", DEPTH, 1'b0);
        swap();
        chk_state("l3_swap", 0, 1'b1);
        rd("l3_31", 5'd31, mk(7, 3, 0, 8'd31, 4'h5), mk(7, 3, 0, 8'd31, 4'h5), 1'b1);
        rd("l3_5", 5'd5, mk(5, 3, 0, 8'd5, 4'h5), mk(5, 3, 0, 8'd5, 4'h5), 1'b1);

        // Clean line clears the overflow flag
        obj(8'hD5, 3'd4, 8'h70, 8'h03, 1'b0, 1'b0);
        swap();
        chk_state("l4_swap", 0, 1'b0);
        rd("l4_0", 5'd0, mk(4, 3, 0, 8'h70, 4'h5), mk(4, 3, 0, 8'h70, 4'h5), 1'b1);
        rd("l4_1", 5'd1, '0, '0, 1'b0);

        // Hit and read coincident with line_start
        obj(8'hD5, 3'd1, 8'h61, 8'h03, 1'b0, 1'b0);
        obj(8'hD5, 3'd2, 8'h62, 8'h03, 1'b0, 1'b0);
        chk_state("l5_wr", 2, 1'b0);
        set_obj(8'hD5, 3'd3, 8'h63, 8'h03, 1'b0, 1'b0);
        push("sw_rd", mk(0, 3, 0, 8'h70, 4'h5), mk(4, 3, 0, 8'h70, 4'h5), 1'b1);
        line_start = 1'b1; rd_en = 1'b1; rd_addr = 5'd0;
        step();
        line_start = 1'b0; rd_en = 1'b0; obj_valid = 1'b0;
        pop_chk();
        chk_state("l5_swap", 0, 1'b0);
        rd("l5_0", 5'd0, mk(1, 3, 0, 8'h61, 4'h5), mk(1, 3, 0, 8'h61, 4'h5), 1'b1);
        rd("l5_1", 5'd1, mk(2, 3, 0, 8'h62, 4'h5), mk(2, 3, 0, 8'h62, 4'h5), 1'b1);

        // cen low freezes everything
        cen = 1'b0;
        set_obj(8'hD5, 3'd3, 8'h64, 8'h03, 1'b0, 1'b0);
        rd_en = 1'b1; rd_addr = 5'd2; line_start = 1'b1;
        step();
        rd_en = 1'b0; obj_valid = 1'b0; line_start = 1'b0; cen = 1'b1;
        chk_state("cen0", 0, 1'b0);
        chk("cen0_data", 32'(rd_data_a), 32'(mk(2, 3, 0, 8'h62, 4'h5)));
        chk("cen0_valid", 32'(rd_valid_a), 32'd1);
        rd("l5_2", 5'd2, '0, '0, 1'b0);

        // Reset mid-line discards both banks
        obj(8'hD5, 3'd1, 8'h81, 8'h03, 1'b0, 1'b0);
        obj(8'hD5, 3'd2, 8'h82, 8'h03, 1'b0, 1'b0);
        obj(8'hD5, 3'd3, 8'h83, 8'h03, 1'b0, 1'b0);
        chk_state("r_pre", 3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_state("r_post", 0, 1'b0);
        swap();
        chk_state("r_swap", 0, 1'b0);
        for (int a = 0; a < 3; a++) begin
            rd("r_rd", 5'(a), '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtpopeye_objline.md
Name: jtpopeye_objline

Overview:
- Parametrised double-buffered object line list. Successor to the 64-entry, fixed-format ping-pong object buffer.
- During line N the block tests each incoming object descriptor against the next scanline and packs hits into the write bank in arrival order.
- At the same time the object renderer reads the hits collected during line N-1 from the other bank.
- Adds: configurable depth, object height and ID width; hit count; per-line overflow flag; optional clear-on-read.

Parameters:
- DEPTH, 32: entries per bank. Must be a power of two, minimum 4. AW = clog2(DEPTH).
- OBJH, 16: object height in lines. Must be 8 or 16. HB = clog2(OBJH).
- IDW, 8: object ID width, bank bit included.
- CLR_ON_READ, 1: when 1, a read zeroes the palette field of the entry that was read.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- cen, in, 1: clock enable. All state advances only when cen=1.
- line_start, in, 1: one-cen pulse at the start of each line. Swaps the banks.
- V, in, 8: current vertical count.
- vcarry, in, 1: carry-in to the zone adder (field/flip correction).
- obj_valid, in, 1: descriptor strobe.
- obj_y, in, 8: object Y.
- obj_x, in, 8: object X. Only [1:0] is stored; X[7:2] is carried by the renderer.
- obj_id, in, IDW: object ID.
- obj_pal, in, 3: palette.
- obj_hflip, in, 1: horizontal flip.
- obj_vflip, in, 1: vertical flip.
- rd_en, in, 1: read strobe.
- rd_addr, in, AW: read index.
- rd_data, out, EW: entry. EW = 3+2+1+IDW+HB. Packing is {pal, x[1:0], hflip, id, row}.
- rd_valid, out, 1: rd_data holds a real hit.
- hit_count, out, AW+1: number of hits written so far into the current write bank.
- overflow, out, 1: the line that was just swapped to read had more hits than DEPTH.

Behaviour:
- Reset state: wbank=0, both bank counts=0, overflow=0, rd_data=0, rd_valid=0, hit_count=0. RAM contents are not reset.
- Zone test, combinational:
  - sum = (obj_y + V + vcarry) mod 256.
  - Hit when sum[7:HB] is all ones, i.e. sum >= 256-OBJH.
  - row = sum[HB-1:0] XOR {HB{obj_vflip}}.
- Write path:
  - Condition: cen & obj_valid & hit & !line_start & (wcount < DEPTH).
  - Action: write the entry to bank[wbank] at index wcount; wcount++.
  - A hit when wcount == DEPTH is dropped and sets ovf_pend.
  - A miss has no effect.
  - One write per cen.
- Swap, on cen & line_start:
  - wbank toggles.
  - rcount <= wcount.
  - overflow <= ovf_pend.
  - New wcount = 0; ovf_pend = 0.
  - An obj_valid in the same cycle is ignored: line_start has priority.
- Read path, on cen & rd_en:
  - Address bank[~wbank] at rd_addr.
  - Next cen: rd_data = entry, rd_valid = (rd_addr < rcount). Latency is 1 cen.
  - When rd_valid would be 0, rd_data is forced to 0.
  - With rd_en=0, rd_data and rd_valid hold their values.
  - If CLR_ON_READ=1: the same cycle writes the palette field to 0 at that address in the read bank. Other fields are kept.
- Read and write access different banks and never collide.
- A read issued in the same cycle as line_start uses the pre-swap read bank.
- hit_count = wcount, registered.
- A rst asserted mid-line discards both banks logically (counts=0). Reads after reset return rd_valid=0.
- Implementation: two DEPTH x EW RAMs, each with a write-port mux, as the existing line buffers use.

Test Plan:
- Reset, then rd_en at rd_addr=0 -> rd_data=0, rd_valid=0, overflow=0, hit_count=0.
- V=0x20, vcarry=0, obj_y=0xD5 (sum=0xF5), vflip=0, pal=5, id=0x12, x=0x03 -> hit, row=5. After line_start, read addr 0 -> {5,3,hflip,0x12,5}, rd_valid=1.
- Same descriptor with vflip=1 -> row=0xA. Same with obj_y=0xCF (sum=0xEF) -> miss, hit_count stays 0.
- DEPTH+3 hits in one line -> hit_count saturates at DEPTH. After line_start overflow=1 and rcount=DEPTH; the next clean line gives overflow=0.
- CLR_ON_READ=1: read addr 0 twice on one line -> the second read returns pal=0 with other fields unchanged. CLR_ON_READ=0 -> pal unchanged.
- obj_valid hit coincident with line_start -> dropped: new hit_count=0, the old line's count is transferred intact. Assert rst after 3 hits, then swap -> rd_valid=0 at all addresses.
